// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - byte-serial instruction memory port between fetch and memory
interface inst_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with direct-mapped icache and byte-serial miss fill
module inst_fetch #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                id_jump_en,
    input  logic [31:0]         id_jpc,
    input  logic                ex_jump_en,
    input  logic [31:0]         ex_jpc,
    inst_fetch_if.master        mem,
    output logic                if_valid,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_inst
);

    localparam int          ENTRIES = 1 << ICACHE_IDX_W;
    localparam int          TAG_W   = 32 - ICACHE_IDX_W - 2;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        B3
    } state_t;

    state_t state, state_nxt;

    logic [31:0] pc, pc_nxt;
    logic        req_q, req_nxt;
    logic [31:0] addr_q, addr_nxt;
    // Only the first three bytes need storing; the fourth arrives with the final ack.
    logic [23:0] asm_q, asm_nxt;
    logic        valid_nxt;
    logic [31:0] ipc_nxt;
    logic [31:0] inst_nxt;

    logic [ENTRIES-1:0] cache_valid;
    logic [TAG_W-1:0]   cache_tag  [ENTRIES];
    logic [31:0]        cache_data [ENTRIES];

    logic [ICACHE_IDX_W-1:0] idx;
    logic [TAG_W-1:0]        tag;
    logic                    hit;
    logic                    cache_we;
    logic [31:0]             fill_word;
    logic                    redirect;
    logic [31:0]             redirect_pc;

    assign idx         = pc[ICACHE_IDX_W+1:2];
    assign tag         = pc[31:ICACHE_IDX_W+2];
    assign hit         = cache_valid[idx] && (cache_tag[idx] == tag);
    assign fill_word   = {mem.mem_rdata, asm_q};
    assign redirect    = ex_jump_en || id_jump_en;
    assign redirect_pc = ex_jump_en ? ex_jpc : id_jpc;

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;

    // Next-state, next-PC, memory request and IF/ID register values.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_nxt   = req_q;
        addr_nxt  = addr_q;
        asm_nxt   = asm_q;
        valid_nxt = if_valid;
        ipc_nxt   = if_pc;
        inst_nxt  = if_inst;
        cache_we  = 1'b0;

        if (redirect) begin
            // Abandon any partial fill and squash the sequential successor.
            pc_nxt    = redirect_pc;
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
            inst_nxt  = NOP;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (!stall) begin
                            valid_nxt = 1'b1;
                            ipc_nxt   = pc;
                            inst_nxt  = cache_data[idx];
                            pc_nxt    = pc + 32'd4;
                        end
                    end else begin
                        state_nxt = B0;
                        req_nxt   = 1'b1;
                        addr_nxt  = pc;
                        if (!stall) begin
                            valid_nxt = 1'b0;
                            inst_nxt  = NOP;
                        end
                    end
                end
                B0, B1, B2: begin
                    if (!stall) begin
                        valid_nxt = 1'b0;
                        inst_nxt  = NOP;
                    end
                    if (mem.mem_ack) begin
                        addr_nxt = addr_q + 32'd1;
                        case (state)
                            B0: begin
                                asm_nxt[7:0] = mem.mem_rdata;
                                state_nxt    = B1;
                            end
                            B1: begin
                                asm_nxt[15:8] = mem.mem_rdata;
                                state_nxt     = B2;
                            end
                            default: begin
                                asm_nxt[23:16] = mem.mem_rdata;
                                state_nxt      = B3;
                            end
                        endcase
                    end
                end
                B3: begin
                    if (!stall) begin
                        valid_nxt = 1'b0;
                        inst_nxt  = NOP;
                    end
                    if (mem.mem_ack) begin
                        cache_we  = 1'b1;
                        req_nxt   = 1'b0;
                        addr_nxt  = addr_q + 32'd1;
                        state_nxt = IDLE;
                        // When stalled the word is only cached; the next IDLE lookup hits it.
                        if (!stall) begin
                            valid_nxt = 1'b1;
                            ipc_nxt   = pc;
                            inst_nxt  = fill_word;
                            pc_nxt    = pc + 32'd4;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, memory port and byte assembly registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            req_q  <= 1'b0;
            addr_q <= 32'h0;
            asm_q  <= 24'h0;
        end else begin
            pc     <= pc_nxt;
            req_q  <= req_nxt;
            addr_q <= addr_nxt;
            asm_q  <= asm_nxt;
        end
    end

    // IF/ID pipeline register; resets to a NOP bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_inst  <= NOP;
        end else begin
            if_valid <= valid_nxt;
            if_pc    <= ipc_nxt;
            if_inst  <= inst_nxt;
        end
    end

    // Cache valid bits; cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid <= '0;
        end else if (cache_we) begin
            cache_valid[idx] <= 1'b1;
        end
    end

    // Cache tag and data arrays, written once a fill completes.
    always_ff @(posedge clk) begin
        if (cache_we) begin
            cache_tag[idx]  <= tag;
            cache_data[idx] <= fill_word;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        id_jump_en;
    logic [31:0] id_jpc;
    logic        ex_jump_en;
    logic [31:0] ex_jpc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    inst_fetch_if mem_bus ();

    inst_fetch #(
        .ICACHE_IDX_W (6),
        .RESET_PC     (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .id_jump_en (id_jump_en),
        .id_jpc     (id_jpc),
        .ex_jump_en (ex_jump_en),
        .ex_jpc     (ex_jpc),
        .mem        (mem_bus.master),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];
    logic        stall_q = 1'b0;
    logic        ack_en  = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0] ^ 16'h5A3C, a[15:0] | 16'h0003};
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        sb_q.push_back({a, word_at(a)});
    endtask

    task automatic wait_out(input logic [31:0] a, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(if_valid && if_pc == a) && n < budget);
        check_eq("wait_out", {31'd0, (if_valid && if_pc == a)}, 64'd1);
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_bus.mem_req && mem_bus.mem_addr == a) && n < budget);
        check_eq("wait_addr", {31'd0, (mem_bus.mem_req && mem_bus.mem_addr == a)}, 64'd1);
    endtask

    // Byte-serial memory: acks every requested cycle unless ack_en is low.
    always @(negedge clk) begin
        mem_bus.mem_ack   = mem_bus.mem_req && ack_en;
        mem_bus.mem_rdata = byte_at(mem_bus.mem_addr);
    end

    always @(posedge clk) stall_q <= stall;

    // Each fresh valid output (not a stall hold) is compared against the queue head.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && if_valid && !stall_q) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_pc", {32'd0, if_pc}, {32'd0, e[63:32]});
                check_eq("sb_inst", {32'd0, if_inst}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        rst        = 1'b0;
        stall      = 1'b0;
        id_jump_en = 1'b0;
        id_jpc     = 32'h0;
        ex_jump_en = 1'b0;
        ex_jpc     = 32'h0;
        repeat (3) @(negedge clk);

        check_eq("rst_req", {63'd0, mem_bus.mem_req}, 64'd0);
        check_eq("rst_addr", {32'd0, mem_bus.mem_addr}, 64'd0);
        check_eq("rst_valid", {63'd0, if_valid}, 64'd0);
        check_eq("rst_pc", {32'd0, if_pc}, 64'd0);
        check_eq("rst_inst", {32'd0, if_inst}, 64'h13);

        // Cold start: two misses fill words 0 and 4.
        push_exp(32'h0);
        push_exp(32'h4);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("fill_req", {63'd0, mem_bus.mem_req}, 64'd1);
            check_eq("fill_addr", {32'd0, mem_bus.mem_addr}, 64'(k));
        end
        @(negedge clk);
        check_eq("first_valid", {63'd0, if_valid}, 64'd1);
        check_eq("first_pc", {32'd0, if_pc}, 64'd0);
        check_eq("first_inst", {32'd0, if_inst}, 64'h13);
        check_eq("first_next_pc", {32'd0, dut.pc}, 64'd4);
        wait_out(32'h4, 20);

        // Loop back to 0: both words hit, no memory traffic.
        ex_jump_en = 1'b1;
        ex_jpc     = 32'h0;
        push_exp(32'h0);
        push_exp(32'h4);
        @(negedge clk);
        ex_jump_en = 1'b0;
        check_eq("loop_bubble", {63'd0, if_valid}, 64'd0);
        check_eq("loop_req0", {63'd0, mem_bus.mem_req}, 64'd0);
        @(negedge clk);
        check_eq("loop_pc0", {31'd0, if_valid, if_pc}, {31'd0, 1'b1, 32'h0});
        check_eq("loop_req1", {63'd0, mem_bus.mem_req}, 64'd0);
        @(negedge clk);
        check_eq("loop_pc4", {31'd0, if_valid, if_pc}, {31'd0, 1'b1, 32'h4});
        check_eq("loop_req2", {63'd0, mem_bus.mem_req}, 64'd0);

        // Fill words 8 and 12, then stream 0..12 from the cache with a stall at pc=8.
        push_exp(32'h8);
        push_exp(32'hC);
        wait_out(32'hC, 40);
        ex_jump_en = 1'b1;
        ex_jpc     = 32'h0;
        for (int a = 0; a < 16; a += 4) push_exp(32'(a));
        @(negedge clk);
        ex_jump_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stall_pc", {31'd0, if_valid, if_pc}, {31'd0, 1'b1, 32'h4});
            check_eq("stall_inst", {32'd0, if_inst}, {32'd0, word_at(32'h4)});
        end
        stall = 1'b0;
        @(negedge clk);
        check_eq("resume_pc8", {31'd0, if_valid, if_pc}, {31'd0, 1'b1, 32'h8});
        @(negedge clk);
        check_eq("resume_pc12", {31'd0, if_valid, if_pc}, {31'd0, 1'b1, 32'hC});

        // JAL redirect while the miss on 16 sits in B2.
        wait_addr(32'h12, 20);
        id_jump_en = 1'b1;
        id_jpc     = 32'h100;
        push_exp(32'h100);
        @(negedge clk);
        id_jump_en = 1'b0;
        ack_en     = 1'b0;
        check_eq("jal_req_drop", {63'd0, mem_bus.mem_req}, 64'd0);
        check_eq("jal_bubble", {63'd0, if_valid}, 64'd0);
        @(negedge clk);
        check_eq("jal_restart", {31'd0, mem_bus.mem_req, mem_bus.mem_addr}, {31'd0, 1'b1, 32'h100});
        @(negedge clk);
        check_eq("no_ack_hold", {31'd0, mem_bus.mem_req, mem_bus.mem_addr}, {31'd0, 1'b1, 32'h100});
        ack_en = 1'b1;
        wait_out(32'h100, 20);

        // The aborted fill of 16 must not have been cached.
        ex_jump_en = 1'b1;
        ex_jpc     = 32'h10;
        push_exp(32'h10);
        @(negedge clk);
        ex_jump_en = 1'b0;
        check_eq("refetch_bubble", {63'd0, if_valid}, 64'd0);
        @(negedge clk);
        check_eq("refetch_miss", {31'd0, mem_bus.mem_req, mem_bus.mem_addr}, {31'd0, 1'b1, 32'h10});
        wait_out(32'h10, 20);

        // Simultaneous redirects: execute wins.
        ex_jump_en = 1'b1;
        ex_jpc     = 32'h40;
        id_jump_en = 1'b1;
        id_jpc     = 32'h80;
        push_exp(32'h40);
        @(negedge clk);
        ex_jump_en = 1'b0;
        id_jump_en = 1'b0;
        @(negedge clk);
        check_eq("prio_addr", {31'd0, mem_bus.mem_req, mem_bus.mem_addr}, {31'd0, 1'b1, 32'h40});
        wait_out(32'h40, 20);

        // Asynchronous reset in the middle of B1.
        wait_addr(32'h45, 20);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_req", {63'd0, mem_bus.mem_req}, 64'd0);
        check_eq("async_valid", {63'd0, if_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        push_exp(32'h0);
        @(negedge clk);
        check_eq("post_rst_miss", {31'd0, mem_bus.mem_req, mem_bus.mem_addr}, {31'd0, 1'b1, 32'h0});
        wait_out(32'h0, 20);
        @(negedge clk);
        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage with a direct-mapped instruction cache, directly upstream of the decode stage. It owns the PC and fetches each 32-bit instruction over a byte-serial memory port, or takes it from the cache on a hit. Its registered outputs act as the IF/ID pipeline register, feeding decode's `PC` and `inst` inputs. It accepts redirects from decode (JAL) and execute (branches, JALR) and honours decode's `stall_request`.

## Interface
- `ICACHE_IDX_W`, default 6: cache index width; gives 2^ICACHE_IDX_W one-word entries.
- `RESET_PC`, default 32'h0: PC value after reset.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode's `stall_request`; when high, the output register holds.
- `id_jump_en`  in  1  JAL redirect from decode.
- `id_jpc`  in  32  JAL target.
- `ex_jump_en`  in  1  branch/JALR redirect from execute.
- `ex_jpc`  in  32  branch/JALR target.
- `mem_req`  out  1  byte read request.
- `mem_addr`  out  32  byte address of the request.
- `mem_ack`  in  1  high for one cycle when `mem_rdata` is valid for `mem_addr`.
- `mem_rdata`  in  8  returned byte.
- `if_valid`  out  1  `if_inst` holds a real instruction.
- `if_pc`  out  32  PC of `if_inst`; drives decode `PC`.
- `if_inst`  out  32  instruction; drives decode `inst`.

## Operation
- Internal state:
  - `pc`: next fetch address.
  - FSM state: IDLE, B0, B1, B2, B3.
  - Byte assembly register.
  - Cache arrays: valid bit, tag `pc[31:ICACHE_IDX_W+2]`, data word. Index is `pc[ICACHE_IDX_W+1:2]`.
- Reset (async, `rst`=0):
  - `pc`=RESET_PC, state=IDLE, all cache valid bits cleared.
  - `mem_req`=0, `mem_addr`=0.
  - `if_valid`=0, `if_pc`=0, `if_inst`=32'h00000013 (ADDI x0,x0,0).
- Redirect priority: `ex_jump_en` > `id_jump_en` > `stall` > normal fetch.
- Redirect, any state, including while stalled:
  - `pc` <= target.
  - State <= IDLE; any partial miss is discarded with no cache write.
  - `mem_req` <= 0.
  - Output becomes a bubble: `if_valid`=0, `if_inst`=NOP, `if_pc` unchanged.
- IDLE with no redirect, hit:
  - If stall=0: output `{1, pc, cache word}`, `pc` += 4.
  - If stall=1: output and `pc` hold.
- IDLE with no redirect, miss:
  - State <= B0, `mem_req` <= 1, `mem_addr` <= `pc`.
  - Output becomes a bubble if stall=0; holds if stall=1.
- Bk (k=0..3), miss fill:
  - `mem_req` stays high and `mem_addr` = `pc`+k.
  - On `mem_ack`: `mem_rdata` is stored into byte lane k (little-endian, bits 8k+7:8k), then `mem_addr` advances to `pc`+k+1 and state to B(k+1).
  - No ack: stay in Bk.
  - While filling, output is a bubble if stall=0; holds if stall=1.
- B3 `mem_ack`:
  - Write `{valid, tag, assembled word}` into the cache. `mem_req` <= 0, state <= IDLE.
  - If stall=0: output `{1, pc, word}` in the same edge and `pc` += 4.
  - If stall=1: output holds, `pc` is unchanged, and the next IDLE lookup hits.
- Arithmetic: `pc` increments are modulo 2^32. Fetches are word-aligned by construction; low PC bits are not checked.
- No cache invalidation other than reset; self-modifying code is unsupported.

## Timing
- Hit latency: lookup in cycle t, outputs valid after edge t+1. Sustained hit throughput is 1 instruction/cycle.
- Miss latency: 1 cycle (IDLE→B0) plus 4 acked bytes. With `mem_ack` every cycle, instruction appears 5 cycles after the lookup.
- `mem_req` is high exactly in B0..B3. It drops the edge after the final ack or after a redirect.
- Outputs are all registered; the only combinational path is cache lookup to the next-state logic.
- A redirect in cycle t bubbles the output at t+1. Fetch of the target begins at t+1.
- Decode's `jump_enable` refers to the instruction currently on `if_inst`; its sequential successor is squashed by the bubble.
- Simultaneous `ex_jump_en` and `id_jump_en`: `ex_jpc` is used.
- Reset mid-miss: immediate abort; the bench sees `mem_req`=0 while `rst`=0.

## Test plan
- Reset, then release; memory returns bytes 13,00,00,00 at addresses 0..3 with one-cycle ack. Required:
  - `mem_addr` steps 0,1,2,3.
  - 5 cycles after release: `if_valid`=1, `if_pc`=0, `if_inst`=32'h00000013, `pc`=4.
- Loop back to 0 via `ex_jump_en`/`ex_jpc`=0 after two words are cached. Required:
  - Bubble for one cycle, then `if_pc` 0, 4 on consecutive cycles.
  - `mem_req` stays 0 throughout.
- `stall`=1 for 3 cycles during hit streaming at `pc`=8. Required: `if_pc`/`if_inst` frozen, then 8 → 12 resumes cleanly.
- `id_jump_en` with `id_jpc`=32'h100 during a miss in state B2. Required:
  - Partial word discarded; no cache write (a later re-fetch of the old address misses again).
  - `mem_addr` restarts at 32'h100.
- `ex_jump_en` (target 32'h40) and `id_jump_en` (target 32'h80) asserted in the same cycle. Required: next fetch at 32'h40.
- `rst` asserted low asynchronously mid-B1. Required: immediately `mem_req`=0, `if_valid`=0, and a subsequent fetch of 0 misses.
